bcd_seq_conv: RTL and testbench

//  Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.

---
 rtl/bcd_seq_conv.sv | 111 +++++++++++
 tb/tb_bcd_seq_conv.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a start/busy/done handshake.
// Optional macro BCD_SAT_EN: an overflowing input publishes all nines instead of the truncated value.
module bcd_seq_conv #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   digits;
    logic [BCD_W-1:0]   digits_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_cap;

    // Add 3 to every digit that would reach 10 or more after the next doubling.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic over_limit(input logic [BIN_W-1:0] b);
        return 64'(b) >= LIMIT;
    endfunction

`ifdef BCD_SAT_EN
    function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] d, input logic ovf);
        return ovf ? {DIGITS{4'h9}} : d;
    endfunction
`endif

    assign digits_adj = add3_digits(digits);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            shreg    <= '0;
            digits   <= '0;
            cnt      <= '0;
            ovf_cap  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        digits  <= '0;
                        cnt     <= '0;
                        ovf_cap <= over_limit(bin);
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Bits leaving the top digit are dropped, giving bin mod 10**DIGITS.
                    digits <= (digits_adj << 1) | BCD_W'(shreg[BIN_W-1]);
                    shreg  <= shreg << 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
`ifdef BCD_SAT_EN
                    bcd <= saturate(digits, ovf_cap);
`else
                    bcd <= digits;
`endif
                    overflow <= ovf_cap;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Self-checking bench for bcd_seq_conv: scoreboard queue of expected results, one task per scenario.
module tb_bcd_seq_conv;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    bcd_seq_conv #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    function automatic exp_t model(input int v);
        exp_t e;
        int   m;
        e.ovf = (v >= 10000);
        m     = v % 10000;
        e.bcd = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
`ifdef BCD_SAT_EN
        if (e.ovf) e.bcd = 16'h9999;
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            step();
            n++;
            if (done) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        start   = 1'b0;
        bin     = '0;
        step();
        step();
        reset_p = 1'b0;
        step();
        n_checks++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0000", bcd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_convert(input int v);
        exp_t e;
        int   n;
        exp_q.push_back(model(v));
        bin   = 14'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL conv_busy(%0d): got %b expected 1", v, busy); end
        wait_done(40, n);
        n_checks++; if (n != 15) begin n_fail++; $display("FAIL conv_latency(%0d): got %0d cycles expected 15", v, n); end
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL conv_queue(%0d): scoreboard empty", v);
        end else begin
            e = exp_q.pop_front();
            n_checks++; if (bcd !== e.bcd) begin n_fail++; $display("FAIL conv_bcd(%0d): got %h expected %h", v, bcd, e.bcd); end
            n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL conv_ovf(%0d): got %b expected %b", v, overflow, e.ovf); end
            step();
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL conv_pulse(%0d): done still %b expected 0", v, done); end
            n_checks++; if (bcd !== e.bcd) begin n_fail++; $display("FAIL conv_hold(%0d): got %h expected %h", v, bcd, e.bcd); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL conv_idle(%0d): busy %b expected 0", v, busy); end
        end
    endtask

    task automatic test_values();
        test_convert(45);
        test_convert(9999);
        test_convert(0);
        test_convert(12345);
        test_convert(10000);
        test_convert(16383);
        for (int i = 0; i < 4; i++) begin
            test_convert(int'($urandom_range(0, 16383)));
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   dones;
        exp_q.push_back(model(27));
        bin   = 14'd27;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        bin   = 14'd99;
        start = 1'b1;
        step();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) begin
                dones++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL ignore_queue: unexpected done, bcd %h", bcd);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (bcd !== e.bcd) begin n_fail++; $display("FAIL ignore_bcd: got %h expected %h", bcd, e.bcd); end
                end
            end
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ignore_dones: got %0d expected 1", dones); end
        n_checks++; if (bcd !== 16'h0027) begin n_fail++; $display("FAIL ignore_hold: got %h expected 0027", bcd); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   dones;
        int   last;
        exp_q.push_back(model(321));
        exp_q.push_back(model(321));
        exp_q.push_back(model(4321));
        exp_q.push_back(model(10000));
        bin   = 14'd321;
        start = 1'b1;
        dones = 0;
        last  = 0;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (i == 20) bin = 14'd4321;
            if (i == 40) bin = 14'd10000;
            if (i == 50) start = 1'b0;
            if (done) begin
                dones++;
                if (last > 0) begin
                    n_checks++; if (i - last != 16) begin n_fail++; $display("FAIL b2b_period: got %0d cycles expected 16", i - last); end
                end
                last = i;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_queue: unexpected done, bcd %h", bcd);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (bcd !== e.bcd) begin n_fail++; $display("FAIL b2b_bcd: got %h expected %h", bcd, e.bcd); end
                    n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL b2b_ovf: got %b expected %b", overflow, e.ovf); end
                end
            end
        end
        n_checks++; if (dones != 4) begin n_fail++; $display("FAIL b2b_dones: got %0d expected 4", dones); end
        exp_q.delete();
    endtask

    task automatic test_abort();
        int dones;
        test_convert(9876);
        bin   = 14'd123;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        reset_p = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        n_checks++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL abort_bcd: got %h expected 0000", bcd); end
        reset_p = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
        n_checks++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL abort_hold: got %h expected 0000", bcd); end
        test_convert(88);
    endtask

    initial begin
        reset_p = 1'b1;
        start   = 1'b0;
        bin     = '0;
        test_reset();
        test_values();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
